// File: rtl/legv8_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the LEGv8 datapath.
// Drives the 34-bit control word and the decoded immediate from state, IR and status.
module legv8_control_unit #(
    parameter logic [4:0] FS_ADD   = 5'b01000,
    parameter logic [4:0] FS_SUB   = 5'b01001,
    parameter logic [4:0] FS_AND   = 5'b00000,
    parameter logic [4:0] FS_ORR   = 5'b00100,
    parameter logic [4:0] FS_PASSA = 5'b00100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [4:0]  status,
    output logic [33:0] ControlWord,
    output logic [63:0] constant,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_LD1    = 3'd3,
        ST_LD2    = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_AND   = 4'd3,
        OP_ORR   = 4'd4,  OP_ADDI = 4'd5,  OP_SUBI = 4'd6,  OP_STUR  = 4'd7,
        OP_LDUR  = 4'd8,  OP_B    = 4'd9,  OP_CBZ  = 4'd10, OP_CBNZ  = 4'd11,
        OP_BCOND = 4'd12
    } op_t;

    state_t      state_r, state_next_s;
    op_t         op_s;
    logic        halted_r;
    logic [31:0] instr_count_r;
    logic        retire_s;

    logic       as_s, pcsel_s, bsel_s, il_s, c0_s, mw_s, rw_s;
    logic [1:0] ds_s, ps_s;
    logic [4:0] fs_s, da_s, sa_s, sb_s;

    // flags = {V,C,N,Z}
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] flags);
        case (cond)
            4'b0000: return flags[0];
            4'b0001: return ~flags[0];
            4'b1010: return (flags[1] == flags[3]);
            4'b1011: return (flags[1] != flags[3]);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction class from the opcode field
    always_comb begin
        op_s = OP_NONE;
        if      (IR[31:21] == 11'b10001011000) op_s = OP_ADD;
        else if (IR[31:21] == 11'b11001011000) op_s = OP_SUB;
        else if (IR[31:21] == 11'b10001010000) op_s = OP_AND;
        else if (IR[31:21] == 11'b10101010000) op_s = OP_ORR;
        else if (IR[31:22] == 10'b1001000100)  op_s = OP_ADDI;
        else if (IR[31:22] == 10'b1101000100)  op_s = OP_SUBI;
        else if (IR[31:21] == 11'b11111000000) op_s = OP_STUR;
        else if (IR[31:21] == 11'b11111000010) op_s = OP_LDUR;
        else if (IR[31:26] == 6'b000101)       op_s = OP_B;
        else if (IR[31:24] == 8'b10110100)     op_s = OP_CBZ;
        else if (IR[31:24] == 8'b10110101)     op_s = OP_CBNZ;
        else if (IR[31:24] == 8'b01010100)     op_s = OP_BCOND;
        else                                   op_s = OP_NONE;
    end

    // Immediate decode; branch offsets subtract 4 because FETCH already advanced the PC
    always_comb begin
        constant = 64'd0;
        case (op_s)
            OP_ADDI, OP_SUBI:
                constant = {52'd0, IR[21:10]};
            OP_STUR, OP_LDUR:
                constant = {{55{IR[20]}}, IR[20:12]};
            OP_B:
                constant = {{36{IR[25]}}, IR[25:0], 2'b00} - 64'd4;
            OP_CBZ, OP_CBNZ, OP_BCOND:
                constant = {{43{IR[23]}}, IR[23:5], 2'b00} - 64'd4;
            default:
                constant = 64'd0;
        endcase
    end

    // Next-state and control-word fields
    always_comb begin
        state_next_s = state_r;
        as_s = 1'b1;  ds_s = 2'b00; ps_s = 2'b00; pcsel_s = 1'b0; bsel_s = 1'b0;
        il_s = 1'b0;  fs_s = FS_PASSA; c0_s = 1'b0; mw_s = 1'b0; rw_s = 1'b0;
        da_s = 5'd31; sa_s = 5'd31; sb_s = 5'd31;
        case (state_r)
            ST_FETCH: begin
                ds_s = 2'b11;
                il_s = 1'b1;
                ps_s = 2'b01;
                state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (op_s == OP_LDUR)      state_next_s = ST_LD1;
                else if (op_s == OP_NONE) state_next_s = ST_HALT;
                else                      state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                state_next_s = ST_FETCH;
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        sa_s = IR[9:5]; sb_s = IR[20:16]; da_s = IR[4:0]; rw_s = 1'b1;
                        case (op_s)
                            OP_ADD:  fs_s = FS_ADD;
                            OP_SUB:  begin fs_s = FS_SUB; c0_s = 1'b1; end
                            OP_AND:  fs_s = FS_AND;
                            default: fs_s = FS_ORR;
                        endcase
                    end
                    OP_ADDI: begin
                        sa_s = IR[9:5]; da_s = IR[4:0]; bsel_s = 1'b1; rw_s = 1'b1; fs_s = FS_ADD;
                    end
                    OP_SUBI: begin
                        sa_s = IR[9:5]; da_s = IR[4:0]; bsel_s = 1'b1; rw_s = 1'b1;
                        fs_s = FS_SUB; c0_s = 1'b1;
                    end
                    OP_STUR: begin
                        sa_s = IR[9:5]; sb_s = IR[4:0]; bsel_s = 1'b1; fs_s = FS_ADD;
                        as_s = 1'b0; ds_s = 2'b01; mw_s = 1'b1;
                    end
                    OP_B: begin
                        ps_s = 2'b10; pcsel_s = 1'b1;
                    end
                    OP_CBZ, OP_CBNZ: begin
                        sa_s = IR[4:0];
                        if (status[0] == (op_s == OP_CBZ)) begin
                            ps_s = 2'b10; pcsel_s = 1'b1;
                        end else begin
                            ps_s = 2'b00; pcsel_s = 1'b0;
                        end
                    end
                    OP_BCOND: begin
                        if (cond_met(IR[3:0], status[4:1])) begin
                            ps_s = 2'b10; pcsel_s = 1'b1;
                        end else begin
                            ps_s = 2'b00; pcsel_s = 1'b0;
                        end
                    end
                    default: begin
                        ps_s = 2'b00;
                    end
                endcase
            end
            ST_LD1, ST_LD2: begin
                sa_s = IR[9:5]; bsel_s = 1'b1; fs_s = FS_ADD; as_s = 1'b0; ds_s = 2'b11;
                if (state_r == ST_LD2) begin
                    da_s = IR[4:0]; rw_s = 1'b1; state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_LD2;
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_HALT;
        endcase
    end

    assign retire_s    = (state_r == ST_EXEC) || (state_r == ST_LD2);
    assign ControlWord = reset ? 34'd0
                       : {as_s, ds_s, ps_s, pcsel_s, bsel_s, il_s, 1'b0, fs_s, c0_s,
                          2'b11, mw_s, rw_s, da_s, sa_s, sb_s};
    assign state       = state_r;
    assign halted      = halted_r;
    assign instr_count = instr_count_r;

    // State, halt flag and retirement counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_FETCH;
            halted_r      <= 1'b0;
            instr_count_r <= 32'd0;
        end else begin
            state_r       <= state_next_s;
            halted_r      <= (state_next_s == ST_HALT);
            instr_count_r <= instr_count_r + {31'd0, retire_s};
        end
    end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench for legv8_control_unit: per-cycle expectations are queued as
// stimulus is applied and compared against the outputs on the falling edge.
module tb_legv8_control_unit;

    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_PASSA = 5'b00100;

    logic        clock;
    logic        reset;
    logic [31:0] IR;
    logic [4:0]  status;
    logic [33:0] ControlWord;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] instr_count;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [33:0] cw;
        logic [63:0] k;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks;
    int          n_fails;
    logic [31:0] exp_cnt;
    logic [33:0] cw_d, cw_f, cw_br;

    legv8_control_unit dut (
        .clock(clock), .reset(reset), .IR(IR), .status(status),
        .ControlWord(ControlWord), .constant(constant), .state(state),
        .halted(halted), .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [33:0] mk(input logic as_, input logic [1:0] ds, input logic [1:0] ps,
                                       input logic pcsel, input logic bsel, input logic il,
                                       input logic [4:0] fs, input logic c0, input logic mw,
                                       input logic rw, input logic [4:0] da, input logic [4:0] sa,
                                       input logic [4:0] sb_);
        return {as_, ds, ps, pcsel, bsel, il, 1'b0, fs, c0, 2'b11, mw, rw, da, sa, sb_};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // One cycle of stimulus plus the outputs expected during that cycle
    task automatic cyc(input string tag, input logic rst, input logic [31:0] ir,
                       input logic [4:0] sts, input logic [2:0] st, input logic [33:0] cw,
                       input logic [63:0] k);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; IR = ir; status = sts;
        e.tag = tag; e.st = st; e.cw = cw; e.k = k; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ir, input logic [4:0] sts,
                             input logic [63:0] k, input logic [33:0] exec_cw,
                             input logic is_ld, input logic [33:0] ld2_cw, input logic wrap);
        cyc({tag, ".fetch"}, 1'b0, ir, sts, 3'd0, cw_f, k);
        if (wrap) begin
            @(negedge clock);
            #1;
            force dut.instr_count_r = 32'hFFFF_FFFF;
            exp_cnt = 32'hFFFF_FFFF;
            #1;
            release dut.instr_count_r;
        end
        cyc({tag, ".decode"}, 1'b0, ir, sts, 3'd1, cw_d, k);
        if (is_ld) begin
            cyc({tag, ".ld1"}, 1'b0, ir, sts, 3'd3, exec_cw, k);
            cyc({tag, ".ld2"}, 1'b0, ir, sts, 3'd4, ld2_cw, k);
        end else begin
            cyc({tag, ".exec"}, 1'b0, ir, sts, 3'd2, exec_cw, k);
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    // Scoreboard consumer: compare the oldest expectation mid-cycle
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_eq({mon_e.tag, ".cw"},     {30'd0, ControlWord}, {30'd0, mon_e.cw});
            check_eq({mon_e.tag, ".k"},      constant, mon_e.k);
            check_eq({mon_e.tag, ".state"},  {61'd0, state}, {61'd0, mon_e.st});
            check_eq({mon_e.tag, ".halted"}, {63'd0, halted}, {63'd0, (mon_e.st == 3'd7)});
            check_eq({mon_e.tag, ".count"},  {32'd0, instr_count}, {32'd0, mon_e.cnt});
        end
    end

    initial begin
        logic [31:0] ir_add, ir_ldur, ir_lt, ir_cbz;
        n_checks = 0; n_fails = 0; exp_cnt = 32'd0;
        reset = 1'b1; IR = 32'd0; status = 5'd0;
        cw_d  = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_PASSA, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
        cw_f  = mk(1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1, FS_PASSA, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
        cw_br = mk(1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, FS_PASSA, 1'b0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31);
        ir_add  = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3};
        ir_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd5};
        ir_lt   = {8'b01010100, 19'h7FFFE, 1'b0, 4'b1011};
        ir_cbz  = {8'b10110100, 19'd3, 5'd7};

        cyc("rst0", 1'b1, 32'd0, 5'd0, 3'd0, 34'd0, 64'd0);
        cyc("rst1", 1'b1, 32'd0, 5'd0, 3'd0, 34'd0, 64'd0);

        run_instr("add", ir_add, 5'd0, 64'd0,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2),
                  1'b0, 34'd0, 1'b0);
        run_instr("sub", {11'b11001011000, 5'd12, 6'd0, 5'd11, 5'd10}, 5'd0, 64'd0,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b1, 5'd10, 5'd11, 5'd12),
                  1'b0, 34'd0, 1'b0);
        run_instr("addi", {10'b1001000100, 12'hFFF, 5'd6, 5'd4}, 5'd0, 64'h0FFF,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1, 5'd4, 5'd6, 5'd31),
                  1'b0, 34'd0, 1'b0);
        run_instr("subi", {10'b1101000100, 12'd1, 5'd2, 5'd2}, 5'd0, 64'd1,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd31),
                  1'b0, 34'd0, 1'b0);
        run_instr("ldur", ir_ldur, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8,
                  mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b0, 5'd31, 5'd4, 5'd31),
                  1'b1,
                  mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1, 5'd5, 5'd4, 5'd31),
                  1'b0);
        run_instr("stur", {11'b11111000000, 9'd16, 2'b00, 5'd2, 5'd9}, 5'd0, 64'd16,
                  mk(1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b1, 1'b0, 5'd31, 5'd2, 5'd9),
                  1'b0, 34'd0, 1'b0);
        run_instr("cbz_t", ir_cbz, 5'b00001, 64'd8,
                  mk(1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, FS_PASSA, 1'b0, 1'b0, 1'b0, 5'd31, 5'd7, 5'd31),
                  1'b0, 34'd0, 1'b0);
        run_instr("cbz_nt", ir_cbz, 5'b00000, 64'd8,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_PASSA, 1'b0, 1'b0, 1'b0, 5'd31, 5'd7, 5'd31),
                  1'b0, 34'd0, 1'b0);
        run_instr("cbnz_t", {8'b10110101, 19'd3, 5'd7}, 5'b00000, 64'd8,
                  mk(1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, FS_PASSA, 1'b0, 1'b0, 1'b0, 5'd31, 5'd7, 5'd31),
                  1'b0, 34'd0, 1'b0);
        run_instr("b", {6'b000101, 26'h3FF_FFFF}, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, cw_br, 1'b0, 34'd0, 1'b0);
        run_instr("blt_t", ir_lt, 5'b00100, 64'hFFFF_FFFF_FFFF_FFF4, cw_br, 1'b0, 34'd0, 1'b0);
        run_instr("blt_nt", ir_lt, 5'b00000, 64'hFFFF_FFFF_FFFF_FFF4, cw_d, 1'b0, 34'd0, 1'b0);
        run_instr("bc12_nt", {8'b01010100, 19'h7FFFE, 1'b0, 4'b1100}, 5'b00100,
                  64'hFFFF_FFFF_FFFF_FFF4, cw_d, 1'b0, 34'd0, 1'b0);
        run_instr("beq_t", {8'b01010100, 19'd1, 1'b0, 4'b0000}, 5'b00010, 64'd0, cw_br, 1'b0, 34'd0, 1'b0);
        run_instr("orr_wrap", {11'b10101010000, 5'd3, 6'd0, 5'd2, 5'd1}, 5'd0, 64'd0,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_ORR, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3),
                  1'b0, 34'd0, 1'b1);

        // Reset arriving during LD2 aborts the load without retiring it
        cyc("abort.fetch", 1'b0, ir_ldur, 5'd0, 3'd0, cw_f, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc("abort.decode", 1'b0, ir_ldur, 5'd0, 3'd1, cw_d, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc("abort.ld1", 1'b0, ir_ldur, 5'd0, 3'd3,
            mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b0, 5'd31, 5'd4, 5'd31),
            64'hFFFF_FFFF_FFFF_FFF8);
        cyc("abort.rst", 1'b1, ir_ldur, 5'd0, 3'd4, 34'd0, 64'hFFFF_FFFF_FFFF_FFF8);
        exp_cnt = 32'd0;
        run_instr("add2", ir_add, 5'd0, 64'd0,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2),
                  1'b0, 34'd0, 1'b0);

        // Unrecognised opcode parks the controller until reset
        cyc("halt.fetch", 1'b0, 32'd0, 5'd0, 3'd0, cw_f, 64'd0);
        cyc("halt.decode", 1'b0, 32'd0, 5'd0, 3'd1, cw_d, 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("halt%0d", i), 1'b0, ir_add, 5'b11111, 3'd7, cw_d, 64'd0);
        end
        cyc("halt.rst0", 1'b1, 32'd0, 5'd0, 3'd7, 34'd0, 64'd0);
        exp_cnt = 32'd0;
        cyc("halt.rst1", 1'b1, 32'd0, 5'd0, 3'd0, 34'd0, 64'd0);
        run_instr("add3", ir_add, 5'd0, 64'd0,
                  mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2),
                  1'b0, 34'd0, 1'b0);
        cyc("final.fetch", 1'b0, ir_add, 5'd0, 3'd0, cw_f, 64'd0);

        repeat (3) @(negedge clock);
        #1;
        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
# legv8_control_unit

Multi-cycle fetch/decode/execute controller for the LEGv8 datapath, including its attached RAM and ROM. Each cycle it drives the datapath's 34-bit control word and 64-bit constant from a state machine, using the instruction register contents and the status flags. It sits above the datapath in the top level and is the only source of the control word in normal operation.

## Interface
Parameters:
- FS_ADD, 5'b01000: ALU function select for A+B.
- FS_SUB, 5'b01001: FS for A-B (C0 is also driven 1).
- FS_AND, 5'b00000: FS for A AND B.
- FS_ORR, 5'b00100: FS for A OR B.
- FS_PASSA, 5'b00100: FS that passes A through to F (OR with B = XZR).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- IR  input  32  instruction register output from the datapath.
- status  input  5  {V,C,N,Z} from the status register in bits [4:1]; bit [0] is the live ALU Z for the current cycle.
- ControlWord  output  34  {AS, DS[1:0], PS[1:0], PCsel, Bsel, IL, SL, FS[4:0], C0, size[1:0], MW, RW, DA, SA, SB}.
- constant  output  64  immediate decoded combinationally from IR.
- state  output  3  current FSM state, for debug.
- halted  output  1  high in the HALT state.
- instr_count  output  32  count of retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, LD1=3, LD2=4, HALT=7.
- Default control word (every state, unless listed below):
  - AS=1, DS=00, PS=00 (hold), PCsel=0, Bsel=0, IL=0, SL=0, FS=FS_PASSA, C0=0, size=11, MW=0, RW=0.
  - DA=SA=SB=31.
- FETCH: AS=1 (PC drives address), DS=11 (memory drives data), IL=1, PS=01 (PC+4). Next state is DECODE.
- DECODE: no side effects. Classify IR, then go to EXEC, or LD1 for LDUR. Unrecognised opcode -> HALT.
- EXEC (single cycle, then FETCH). Instruction actions:
  - ADD/SUB/AND/ORR (IR[31:21]=10001011000/11001011000/10001010000/10101010000): SA=Rn, SB=Rm, DA=Rd, Bsel=0, matching FS, DS=00, RW=1.
  - ADDI/SUBI (IR[31:22]=1001000100/1101000100): SA=Rn, DA=Rd, Bsel=1, RW=1.
  - STUR (11111000000): SA=Rn, Bsel=1, FS_ADD, AS=0 (ALU drives address), SB=Rt, DS=01, MW=1.
  - B (IR[31:26]=000101): PS=10, PCsel=1.
  - CBZ/CBNZ (IR[31:24]=10110100/10110101): SA=Rt, FS_PASSA. Taken when status[0]==1 (CBZ) or ==0 (CBNZ). Taken -> PS=10, PCsel=1; not taken -> PS=00.
  - B.cond (IR[31:24]=01010100): condition in IR[3:0], evaluated on status[4:1].
    - Taken: EQ(0000) Z; NE(0001) !Z; GE(1010) N==V; LT(1011) N!=V; AL(1110) always.
    - Any other code is not taken.
- LDUR (11111000010):
  - LD1: SA=Rn, Bsel=1, FS_ADD, AS=0, DS=11, RW=0.
  - LD2: identical to LD1, plus DA=Rt and RW=1. Then FETCH.
- HALT: default control word. Stays in HALT until reset.
- constant (combinational, by class; all others 0):
  - I-type: zero-extend IR[21:10].
  - D-type: sign-extend IR[20:12].
  - B: (sign-extend IR[25:0] << 2) - 4.
  - CB/B.cond: (sign-extend IR[23:5] << 2) - 4.
  - The -4 compensates for the PC increment already applied in FETCH.
- instr_count: +1 on the edge leaving EXEC or LD2, modulo 2^32 (wraps FFFFFFFF -> 0).

## Timing
- Reset: while reset=1, ControlWord=0 (no writes, no IL, no PC change) and constant is unaffected. On the edge, state=FETCH, instr_count=0, halted=0.
- Reset mid-instruction: aborts at the next edge. Any partial LD1 has no effect because RW=0 in LD1.
- Latency in cycles: ALU ops, immediates, stores and branches take 3 (FETCH, DECODE, EXEC). LDUR takes 4.
- ControlWord and constant are purely combinational from state, IR and status. The conditional PS in CBZ/CBNZ depends on status[0] within the same cycle.
- IR is loaded at the FETCH->DECODE edge. The PC is updated at the FETCH edge and again at the EXEC edge only for taken branches.
- Exactly one data-bus driver per cycle: DS is never 11 in the same cycle as MW=1.

## Test plan
- Reset with IR=0 for 2 cycles -> ControlWord=0 throughout; then state=0, instr_count=0, halted=0.
- IR=ADD X3,X1,X2 -> FETCH word has IL=1, PS=01, DS=11, AS=1. EXEC word has SA=1, SB=2, DA=3, FS=FS_ADD, RW=1. instr_count=1 after 3 cycles.
- IR=LDUR X5,[X4,#-8] -> constant=FFFFFFFFFFFFFFF8. LD1 has RW=0, AS=0, DS=11. LD2 has RW=1, DA=5. FETCH follows after 4 cycles.
- IR=CBZ X7,#+3 instructions -> constant=8. With status[0]=1: PS=10, PCsel=1. With status[0]=0: PS=00.
- IR=B.cond LT with status[4:1]={V=0,C=0,N=1,Z=0} -> taken. Same IR with N=0 -> not taken. cond=1100 -> never taken.
- IR=32'h00000000 -> HALT after DECODE; halted=1 persists 10 cycles; instr_count unchanged. Reset returns to FETCH.
- instr_count preset near wrap via 2^32-1 retirements (or force) -> next retirement reads 0.
